// File: rtl/polaris_fetch_queue.sv
// Instruction prefetch unit: owns the fetch PC, strobes the I bus one request at a time,
// and queues fetched words (or a misaligned-redirect fault) for the sequencer.
module polaris_fetch_queue #(
  parameter int          XLEN      = 64,
  parameter int          DEPTH     = 4,
  parameter logic [63:0] RESET_VEC = 64'hFFFF_FFFF_FFFF_FF00
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   redirect_i,
  input  logic [XLEN-1:0]        redirect_pc_i,
  output logic [XLEN-1:0]        iadr_o,
  output logic [1:0]             isiz_o,
  output logic                   istb_o,
  input  logic                   iack_i,
  input  logic [31:0]            idat_i,
  output logic                   ivalid_o,
  output logic [31:0]            iinst_o,
  output logic [XLEN-1:0]        ipc_o,
  output logic                   ifault_o,
  input  logic                   iready_i,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {FETCH, HALT} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] fpc_q;
  logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q;

  logic            fault_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [31:0]     inst_mem  [DEPTH];

  logic strobe, accept, pop, misaligned, head_vld;

  always_comb begin
    state_d    = state_q;
    misaligned = (redirect_pc_i[1:0] != 2'b00);
    strobe     = (state_q == FETCH) && (count_q != FULL_CNT) && !redirect_i && reset_i;
    accept     = strobe && iack_i;
    head_vld   = reset_i && (count_q != '0);
    // Redirect outranks both the bus ack and the sequencer pop.
    pop        = head_vld && iready_i && !redirect_i;
    if (redirect_i) begin
      state_d = misaligned ? HALT : FETCH;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q  <= FETCH;
      fpc_q    <= RESET_VEC[XLEN-1:0];
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      if (redirect_i) begin
        rd_ptr_q <= '0;
        if (misaligned) begin
          wr_ptr_q <= AW'(1);
          count_q  <= CW'(1);
        end else begin
          wr_ptr_q <= '0;
          count_q  <= '0;
          fpc_q    <= redirect_pc_i;
        end
      end else begin
        if (accept) begin
          wr_ptr_q <= wr_ptr_q + AW'(1);
          fpc_q    <= fpc_q + XLEN'(4);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + AW'(1);
        end
        if (accept && !pop) begin
          count_q <= count_q + CW'(1);
        end else if (pop && !accept) begin
          count_q <= count_q - CW'(1);
        end
      end
    end
  end

  // Entry storage carries no reset; count_q alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (redirect_i) begin
      if (misaligned) begin
        fault_mem[0] <= 1'b1;
        pc_mem[0]    <= redirect_pc_i;
        inst_mem[0]  <= '0;
      end
    end else if (accept) begin
      fault_mem[wr_ptr_q] <= 1'b0;
      pc_mem[wr_ptr_q]    <= fpc_q;
      inst_mem[wr_ptr_q]  <= idat_i;
    end
  end

  assign istb_o   = strobe;
  assign iadr_o   = strobe ? fpc_q : '0;
  assign isiz_o   = strobe ? 2'b10 : 2'b00;
  assign ivalid_o = head_vld;
  assign ipc_o    = head_vld ? pc_mem[rd_ptr_q] : '0;
  assign iinst_o  = head_vld ? inst_mem[rd_ptr_q] : '0;
  assign ifault_o = head_vld && fault_mem[rd_ptr_q];
  assign count_o  = reset_i ? count_q : '0;

endmodule

// File: tb/tb_polaris_fetch_queue.sv
// Bench for polaris_fetch_queue: scenario tasks checked against a queue-based model
// of the prefetch buffer, fetch PC and halt condition.
module tb_polaris_fetch_queue;

  localparam int XLEN = 64;
  localparam int DEPTH = 4;
  localparam logic [63:0] RVEC = 64'hFFFF_FFFF_FFFF_FF00;

  logic            clk_i = 1'b0;
  logic            reset_i = 1'b0;
  logic            redirect_i = 1'b0;
  logic [XLEN-1:0] redirect_pc_i = '0;
  logic [XLEN-1:0] iadr_o;
  logic [1:0]      isiz_o;
  logic            istb_o;
  logic            iack_i = 1'b0;
  logic [31:0]     idat_i = '0;
  logic            ivalid_o;
  logic [31:0]     iinst_o;
  logic [XLEN-1:0] ipc_o;
  logic            ifault_o;
  logic            iready_i = 1'b0;
  logic [2:0]      count_o;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic        fault;
    logic [63:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        m_q[$];
  logic [63:0] m_fpc = RVEC;
  logic        m_halt = 1'b0;

  polaris_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_VEC(RVEC)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .iadr_o(iadr_o), .isiz_o(isiz_o), .istb_o(istb_o), .iack_i(iack_i), .idat_i(idat_i),
    .ivalid_o(ivalid_o), .iinst_o(iinst_o), .ipc_o(ipc_o), .ifault_o(ifault_o),
    .iready_i(iready_i), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got=running exp=finished");
    $fatal(1, "timeout");
  end

  function automatic logic e_istb();
    return !m_halt && (m_q.size() != DEPTH) && !redirect_i && reset_i;
  endfunction

  function automatic logic e_valid();
    return reset_i && (m_q.size() != 0);
  endfunction

  // Applies the rules of one rising edge to the model, then advances the clock.
  task automatic tick();
    logic acc, pp;
    ent_t e;
    acc = e_istb() && iack_i;
    pp  = e_valid() && iready_i;
    if (!reset_i) begin
      m_q.delete();
      m_fpc  = RVEC;
      m_halt = 1'b0;
    end else if (redirect_i) begin
      m_q.delete();
      if (redirect_pc_i[1:0] == 2'b00) begin
        m_fpc  = redirect_pc_i;
        m_halt = 1'b0;
      end else begin
        e = '{1'b1, redirect_pc_i, 32'h0};
        m_q.push_back(e);
        m_halt = 1'b1;
      end
    end else begin
      if (pp) m_q.delete(0);
      if (acc) begin
        e = '{1'b0, m_fpc, idat_i};
        m_q.push_back(e);
        m_fpc = m_fpc + 64'd4;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b0; iack_i = 1'b1; iready_i = 1'b1;
    tick(); tick();
    #1;
    total++; if (istb_o !== 1'b0) begin bad++; $display("FAIL reset_istb got=%b exp=0", istb_o); end
    total++; if (iadr_o !== '0) begin bad++; $display("FAIL reset_iadr got=%h exp=0", iadr_o); end
    total++; if (isiz_o !== 2'b00) begin bad++; $display("FAIL reset_isiz got=%b exp=00", isiz_o); end
    total++; if (ivalid_o !== 1'b0) begin bad++; $display("FAIL reset_ivalid got=%b exp=0", ivalid_o); end
    total++; if (count_o !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count_o); end
    total++; if (ipc_o !== '0 || iinst_o !== '0 || ifault_o !== 1'b0) begin
      bad++; $display("FAIL reset_head got pc=%h inst=%h f=%b exp=0", ipc_o, iinst_o, ifault_o);
    end
  endtask

  task automatic test_fill();
    reset_i = 1'b1; iack_i = 1'b1; iready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      idat_i = $urandom;
      #1;
      total++; if (istb_o !== e_istb()) begin bad++; $display("FAIL fill_istb[%0d] got=%b exp=%b", i, istb_o, e_istb()); end
      total++; if (iadr_o !== (e_istb() ? m_fpc : 64'h0)) begin
        bad++; $display("FAIL fill_iadr[%0d] got=%h exp=%h", i, iadr_o, e_istb() ? m_fpc : 64'h0);
      end
      total++; if (count_o !== 3'(m_q.size())) begin bad++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count_o, m_q.size()); end
      tick();
    end
    #1;
    total++; if (count_o !== 3'd4 || istb_o !== 1'b0) begin
      bad++; $display("FAIL fill_full got count=%0d istb=%b exp count=4 istb=0", count_o, istb_o);
    end
    total++; if (ipc_o !== 64'hFFFF_FFFF_FFFF_FF00 || iinst_o !== m_q[0].inst) begin
      bad++; $display("FAIL fill_head got pc=%h inst=%h exp pc=ffffffffffffff00 inst=%h", ipc_o, iinst_o, m_q[0].inst);
    end
  endtask

  task automatic test_full_pop();
    logic [63:0] exp_pc [4];
    exp_pc[0] = 64'hFFFF_FFFF_FFFF_FF04; exp_pc[1] = 64'hFFFF_FFFF_FFFF_FF08;
    exp_pc[2] = 64'hFFFF_FFFF_FFFF_FF0C; exp_pc[3] = 64'hFFFF_FFFF_FFFF_FF10;
    iready_i = 1'b1; idat_i = $urandom;
    #1;
    total++; if (istb_o !== 1'b0 || ivalid_o !== 1'b1) begin
      bad++; $display("FAIL fullpop_pre got istb=%b vld=%b exp istb=0 vld=1", istb_o, ivalid_o);
    end
    tick();
    iready_i = 1'b0;
    #1;
    total++; if (count_o !== 3'd3) begin bad++; $display("FAIL fullpop_count got=%0d exp=3", count_o); end
    total++; if (istb_o !== 1'b1 || iadr_o !== 64'hFFFF_FFFF_FFFF_FF10 || isiz_o !== 2'b10) begin
      bad++; $display("FAIL fullpop_refetch got istb=%b adr=%h siz=%b exp 1 ffffffffffffff10 10", istb_o, iadr_o, isiz_o);
    end
    tick();
    iack_i = 1'b0; iready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (ipc_o !== exp_pc[i] || iinst_o !== m_q[0].inst) begin
        bad++; $display("FAIL drain_head[%0d] got pc=%h inst=%h exp pc=%h inst=%h", i, ipc_o, iinst_o, exp_pc[i], m_q[0].inst);
      end
      tick();
    end
    iready_i = 1'b0;
    #1;
    total++; if (count_o !== 3'd0 || ivalid_o !== 1'b0) begin
      bad++; $display("FAIL drain_empty got count=%0d vld=%b exp 0 0", count_o, ivalid_o);
    end
  endtask

  task automatic test_redirect_drop();
    iack_i = 1'b1; idat_i = $urandom;
    tick();
    redirect_i = 1'b1; redirect_pc_i = 64'h1000; iready_i = 1'b1; idat_i = $urandom;
    #1;
    total++; if (istb_o !== 1'b0) begin bad++; $display("FAIL redir_mask got istb=%b exp=0", istb_o); end
    tick();
    redirect_i = 1'b0; iack_i = 1'b0; iready_i = 1'b0;
    #1;
    total++; if (count_o !== 3'd0 || ivalid_o !== 1'b0) begin
      bad++; $display("FAIL redir_flush got count=%0d vld=%b exp 0 0", count_o, ivalid_o);
    end
    total++; if (istb_o !== 1'b1 || iadr_o !== 64'h1000) begin
      bad++; $display("FAIL redir_addr got istb=%b adr=%h exp 1 1000", istb_o, iadr_o);
    end
    tick();
  endtask

  task automatic test_misaligned();
    redirect_i = 1'b1; redirect_pc_i = 64'h1002;
    tick();
    redirect_i = 1'b0; iack_i = 1'b1; iready_i = 1'b0;
    #1;
    total++; if (ivalid_o !== 1'b1 || ifault_o !== 1'b1 || ipc_o !== 64'h1002 || iinst_o !== 32'h0) begin
      bad++; $display("FAIL fault_entry got v=%b f=%b pc=%h inst=%h exp 1 1 1002 0", ivalid_o, ifault_o, ipc_o, iinst_o);
    end
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (istb_o !== 1'b0 || count_o !== 3'd1) begin
        bad++; $display("FAIL halt_hold[%0d] got istb=%b count=%0d exp 0 1", i, istb_o, count_o);
      end
      tick();
    end
    iready_i = 1'b1;
    tick();
    iready_i = 1'b0;
    #1;
    total++; if (ivalid_o !== 1'b0 || istb_o !== 1'b0 || ifault_o !== 1'b0) begin
      bad++; $display("FAIL halt_empty got v=%b istb=%b f=%b exp 0 0 0", ivalid_o, istb_o, ifault_o);
    end
    redirect_i = 1'b1; redirect_pc_i = 64'h2000; iack_i = 1'b0;
    tick();
    redirect_i = 1'b0;
    #1;
    total++; if (istb_o !== 1'b1 || iadr_o !== 64'h2000) begin
      bad++; $display("FAIL halt_exit got istb=%b adr=%h exp 1 2000", istb_o, iadr_o);
    end
  endtask

  task automatic test_wrap();
    redirect_i = 1'b1; redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFFC; iack_i = 1'b1;
    tick();
    redirect_i = 1'b0; idat_i = $urandom;
    #1;
    total++; if (iadr_o !== 64'hFFFF_FFFF_FFFF_FFFC) begin bad++; $display("FAIL wrap_adr0 got=%h exp=fffffffffffffffc", iadr_o); end
    tick();
    idat_i = $urandom;
    #1;
    total++; if (iadr_o !== 64'h0 || istb_o !== 1'b1) begin bad++; $display("FAIL wrap_adr1 got=%h istb=%b exp=0 1", iadr_o, istb_o); end
    tick();
    iack_i = 1'b0;
    #1;
    total++; if (ipc_o !== 64'hFFFF_FFFF_FFFF_FFFC || count_o !== 3'd2) begin
      bad++; $display("FAIL wrap_head0 got pc=%h count=%0d exp fffffffffffffffc 2", ipc_o, count_o);
    end
    iready_i = 1'b1;
    tick();
    #1;
    total++; if (ipc_o !== 64'h0 || iinst_o !== m_q[0].inst) begin
      bad++; $display("FAIL wrap_head1 got pc=%h inst=%h exp 0 %h", ipc_o, iinst_o, m_q[0].inst);
    end
    tick();
    iready_i = 1'b0;
  endtask

  task automatic test_wait_reset();
    int          wcnt;
    logic        pend;
    logic [63:0] pend_adr;
    logic        found;
    logic [63:0] e_pc;
    logic [31:0] e_inst;
    logic        e_f;
    wcnt = 0; pend = 1'b0; pend_adr = '0;
    for (int i = 0; i < 160; i++) begin
      iready_i = 1'($urandom_range(0, 1));
      idat_i   = $urandom;
      iack_i   = e_istb() ? (wcnt >= 3) : 1'($urandom_range(0, 1));
      #1;
      e_pc   = e_valid() ? m_q[0].pc : 64'h0;
      e_inst = e_valid() ? m_q[0].inst : 32'h0;
      e_f    = e_valid() ? m_q[0].fault : 1'b0;
      total++; if (istb_o !== e_istb() || iadr_o !== (e_istb() ? m_fpc : 64'h0)) begin
        bad++; $display("FAIL rnd_bus[%0d] got istb=%b adr=%h exp %b %h", i, istb_o, iadr_o, e_istb(), e_istb() ? m_fpc : 64'h0);
      end
      total++; if (ivalid_o !== e_valid() || ipc_o !== e_pc || iinst_o !== e_inst || ifault_o !== e_f) begin
        bad++; $display("FAIL rnd_head[%0d] got v=%b pc=%h inst=%h f=%b exp %b %h %h %b", i, ivalid_o, ipc_o, iinst_o, ifault_o,
                        e_valid(), e_pc, e_inst, e_f);
      end
      total++; if (count_o !== 3'(m_q.size())) begin bad++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d", i, count_o, m_q.size()); end
      if (pend) begin
        total++; if (istb_o !== 1'b1 || iadr_o !== pend_adr) begin
          bad++; $display("FAIL rnd_stable[%0d] got istb=%b adr=%h exp 1 %h", i, istb_o, iadr_o, pend_adr);
        end
      end
      pend     = e_istb() && !iack_i;
      pend_adr = m_fpc;
      if (e_istb() && iack_i) wcnt = 0;
      else if (e_istb()) wcnt++;
      tick();
    end
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      iready_i = 1'b1;
      if (e_istb() && wcnt >= 1) begin
        found = 1'b1;
      end else begin
        iack_i = e_istb() ? (wcnt >= 3) : 1'b0;
        if (e_istb() && iack_i) wcnt = 0;
        else if (e_istb()) wcnt++;
        tick();
      end
    end
    total++; if (!found) begin bad++; $display("FAIL rst_pending got=none exp=request_in_wait"); end
    reset_i = 1'b0; iack_i = 1'b1; idat_i = $urandom;
    #1;
    total++; if (istb_o !== 1'b0 || ivalid_o !== 1'b0 || count_o !== 3'd0) begin
      bad++; $display("FAIL rst_mid got istb=%b v=%b count=%0d exp 0 0 0", istb_o, ivalid_o, count_o);
    end
    tick();
    reset_i = 1'b1; iack_i = 1'b0; iready_i = 1'b0;
    #1;
    total++; if (count_o !== 3'd0 || ivalid_o !== 1'b0) begin
      bad++; $display("FAIL rst_after got count=%0d v=%b exp 0 0", count_o, ivalid_o);
    end
    total++; if (istb_o !== 1'b1 || iadr_o !== RVEC) begin
      bad++; $display("FAIL rst_refetch got istb=%b adr=%h exp 1 %h", istb_o, iadr_o, RVEC);
    end
    tick();
    #1;
    total++; if (count_o !== 3'd0) begin bad++; $display("FAIL rst_nostale got=%0d exp=0", count_o); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_pop();
    test_redirect_drop();
    test_misaligned();
    test_wrap();
    test_wait_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
